// File: rtl/desserializador_serial_pkg.sv
// Shared definitions for the serial receiver: FSM state encoding and idle line level.
package desserializador_serial_pkg;

    typedef enum logic [2:0] {
        OCIOSO       = 3'd0,
        DADOS        = 3'd1,
        PARIDADE_ST  = 3'd2,
        PARADA       = 3'd3,
        ESPERA_LINHA = 3'd4
    } estado_t;

    localparam logic LINHA_OCIOSA = 1'b1;

endpackage

// File: rtl/desserializador_serial_registro.sv
// MSB-in serial-to-parallel shift register with shift enable and synchronous clear.
module registro_deslocamento_entrada #(
    parameter int LARGURA = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               limpar_i,
    input  logic               desloca_i,
    input  logic               bit_i,
    output logic [LARGURA-1:0] dado_o
);

    logic [LARGURA-1:0] dado_q, dado_d;

    always_comb begin
        dado_d = dado_q;
        if (limpar_i) begin
            dado_d = '0;
        end else if (desloca_i) begin
            dado_d = {bit_i, dado_q[LARGURA-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dado_q <= '0;
        end else begin
            dado_q <= dado_d;
        end
    end

    assign dado_o = dado_q;

endmodule

// File: rtl/desserializador_serial.sv
// Serial-to-parallel receiver: start bit, LSB-first data, optional parity, stop bit,
// with a holding register offered through a valid/consume handshake.
module desserializador_serial
    import desserializador_serial_pkg::*;
#(
    parameter int LARGURA  = 4,
    parameter int PARIDADE = 1,
    parameter int IMPAR    = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bit_en,
    input  logic               serial_in,
    input  logic               consumir,
    input  logic               limpar_erro,
    output logic [LARGURA-1:0] dado_paralelo,
    output logic               dado_valido,
    output logic               erro_paridade,
    output logic               erro_parada,
    output logic               sobrescrita,
    output logic               recebendo
);

    localparam int CW = $clog2(LARGURA + 1);
    localparam logic [CW-1:0] ULTIMO = CW'(LARGURA - 1);
    localparam logic COM_PARIDADE = (PARIDADE != 0);
    localparam logic SENTIDO_IMPAR = (IMPAR != 0);

    estado_t            estado_q, estado_d;
    logic [CW-1:0]      cont_q, cont_d;
    logic               paridade_q, paridade_d;
    logic [LARGURA-1:0] dado_q, dado_d;
    logic               valido_q, valido_d;
    logic               erro_par_q, erro_par_d;
    logic               erro_parada_q, erro_parada_d;
    logic               sobre_q, sobre_d;

    logic               desloca, limpa, quadro_ok, erro_calc;
    logic [LARGURA-1:0] registro;

    registro_deslocamento_entrada #(.LARGURA(LARGURA)) u_registro (
        .clk       (clk),
        .rst_n     (rst_n),
        .limpar_i  (limpa),
        .desloca_i (desloca),
        .bit_i     (serial_in),
        .dado_o    (registro)
    );

    always_comb begin
        estado_d      = estado_q;
        cont_d        = cont_q;
        paridade_d    = paridade_q;
        desloca       = 1'b0;
        limpa         = 1'b0;
        quadro_ok     = 1'b0;
        erro_parada_d = 1'b0;
        if (bit_en) begin
            unique case (estado_q)
                OCIOSO: begin
                    if (serial_in != LINHA_OCIOSA) begin
                        estado_d = DADOS;
                        cont_d   = '0;
                        limpa    = 1'b1;
                    end
                end
                DADOS: begin
                    desloca = 1'b1;
                    cont_d  = cont_q + CW'(1);
                    if (cont_q == ULTIMO) begin
                        estado_d = COM_PARIDADE ? PARIDADE_ST : PARADA;
                    end
                end
                PARIDADE_ST: begin
                    paridade_d = serial_in;
                    estado_d   = PARADA;
                end
                PARADA: begin
                    if (serial_in) begin
                        quadro_ok = 1'b1;
                        estado_d  = OCIOSO;
                    end else begin
                        erro_parada_d = 1'b1;
                        estado_d      = ESPERA_LINHA;
                    end
                end
                ESPERA_LINHA: begin
                    // A held-low line (break) must see a high sample before a new start bit counts.
                    if (serial_in) estado_d = OCIOSO;
                end
                default: estado_d = OCIOSO;
            endcase
        end
    end

    assign erro_calc = COM_PARIDADE && ((^registro ^ SENTIDO_IMPAR) != paridade_q);

    always_comb begin
        dado_d     = dado_q;
        valido_d   = valido_q;
        erro_par_d = erro_par_q;
        sobre_d    = sobre_q;
        if (limpar_erro) sobre_d = 1'b0;
        if (quadro_ok && (!valido_q || consumir)) begin
            dado_d     = registro;
            erro_par_d = erro_calc;
            valido_d   = 1'b1;
        end else begin
            if (quadro_ok) sobre_d = 1'b1;
            if (consumir) valido_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q      <= OCIOSO;
            cont_q        <= '0;
            paridade_q    <= 1'b0;
            dado_q        <= '0;
            valido_q      <= 1'b0;
            erro_par_q    <= 1'b0;
            erro_parada_q <= 1'b0;
            sobre_q       <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            cont_q        <= cont_d;
            paridade_q    <= paridade_d;
            dado_q        <= dado_d;
            valido_q      <= valido_d;
            erro_par_q    <= erro_par_d;
            erro_parada_q <= erro_parada_d;
            sobre_q       <= sobre_d;
        end
    end

    assign dado_paralelo = dado_q;
    assign dado_valido   = valido_q;
    assign erro_paridade = erro_par_q;
    assign erro_parada   = erro_parada_q;
    assign sobrescrita   = sobre_q;
    assign recebendo     = (estado_q != OCIOSO);

endmodule

// File: tb/tb_desserializador_serial.sv
// Directed bench for desserializador_serial (LARGURA=4, even parity, strobe every 4th clock)
// with a scoreboard queue of expected delivered words.
module tb_desserializador_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_en = 1'b0;
    logic       serial_in = 1'b1;
    logic       consumir = 1'b0;
    logic       limpar_erro = 1'b0;
    logic [3:0] dado_paralelo;
    logic       dado_valido, erro_paridade, erro_parada, sobrescrita, recebendo;

    int total = 0;
    int bad = 0;

    logic [4:0] expQ[$];
    logic [4:0] curExp = '0;
    logic       modelValido = 1'b0;
    logic       modelSobre = 1'b0;

    desserializador_serial #(.LARGURA(4), .PARIDADE(1), .IMPAR(0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bit_en        (bit_en),
        .serial_in     (serial_in),
        .consumir      (consumir),
        .limpar_erro   (limpar_erro),
        .dado_paralelo (dado_paralelo),
        .dado_valido   (dado_valido),
        .erro_paridade (erro_paridade),
        .erro_parada   (erro_parada),
        .sobrescrita   (sobrescrita),
        .recebendo     (recebendo)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s got=%h want=%h", tag, obs, expv);
        end
    endtask

    // One bit period: three idle clocks, then one clock with the strobe high.
    task automatic sendBit(input logic b, input logic cons);
        serial_in = b;
        bit_en    = 1'b0;
        repeat (3) @(negedge clk);
        bit_en   = 1'b1;
        consumir = cons;
        @(negedge clk);
        bit_en   = 1'b0;
        consumir = 1'b0;
    endtask

    task automatic applyStimulus(input logic [3:0] data, input logic badPar,
                                 input logic consAtStop);
        logic par;
        par = (^data) ^ badPar;
        sendBit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) sendBit(data[i], 1'b0);
        sendBit(par, 1'b0);
        sendBit(1'b1, consAtStop);
        if (!modelValido || consAtStop) begin
            expQ.push_back({badPar, data});
            modelValido = 1'b1;
        end else begin
            modelSobre = 1'b1;
        end
    endtask

    task automatic checkOutput(input string tag);
        if (expQ.size() != 0) curExp = expQ.pop_front();
        check({tag, ".dado"}, {4'h0, dado_paralelo}, {4'h0, curExp[3:0]});
        check({tag, ".erro_par"}, {7'h0, erro_paridade}, {7'h0, curExp[4]});
        check({tag, ".valido"}, {7'h0, dado_valido}, {7'h0, modelValido});
        check({tag, ".sobre"}, {7'h0, sobrescrita}, {7'h0, modelSobre});
    endtask

    task automatic consume(input string tag);
        consumir = 1'b1;
        @(negedge clk);
        consumir = 1'b0;
        modelValido = 1'b0;
        check({tag, ".consumido"}, {7'h0, dado_valido}, 8'h00);
    endtask

    initial begin
        $display("[TB] start");
        repeat (2) @(negedge clk);
        check("reset.dado", {4'h0, dado_paralelo}, 8'h00);
        check("reset.valido", {7'h0, dado_valido}, 8'h00);
        check("reset.recebendo", {7'h0, recebendo}, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle.flags", {4'h0, erro_paridade, erro_parada, sobrescrita, recebendo}, 8'h00);

        // Good frame 4'hB with correct parity.
        applyStimulus(4'hB, 1'b0, 1'b0);
        checkOutput("t1");
        check("t1.recebendo", {7'h0, recebendo}, 8'h00);
        consume("t1");

        // Same word with a wrong parity bit is still delivered, flagged.
        applyStimulus(4'hB, 1'b1, 1'b0);
        checkOutput("t2");
        consume("t2");

        // Framing error, then a held-low line.
        sendBit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) sendBit(i[0], 1'b0);
        sendBit(1'b0, 1'b0);
        sendBit(1'b0, 1'b0);
        check("t3.erro_parada", {7'h0, erro_parada}, 8'h01);
        @(negedge clk);
        check("t3.pulso", {7'h0, erro_parada}, 8'h00);
        for (int i = 0; i < 3; i++) sendBit(1'b0, 1'b0);
        check("t3.espera", {7'h0, recebendo}, 8'h01);
        check("t3.sem_entrega", {7'h0, dado_valido}, 8'h00);
        check("t3.sem_pulso", {7'h0, erro_parada}, 8'h00);
        sendBit(1'b1, 1'b0);
        check("t3.ocioso", {7'h0, recebendo}, 8'h00);

        // Overrun: 4'h3 held, 4'h5 dropped.
        applyStimulus(4'h3, 1'b0, 1'b0);
        checkOutput("t4a");
        applyStimulus(4'h5, 1'b0, 1'b0);
        checkOutput("t4b");
        limpar_erro = 1'b1;
        @(negedge clk);
        limpar_erro = 1'b0;
        modelSobre = 1'b0;
        checkOutput("t4c");

        // Consume in the same cycle as the stop sample.
        applyStimulus(4'h5, 1'b0, 1'b1);
        checkOutput("t5");
        consume("t5");

        // Reset asserted mid-frame after the second data bit.
        sendBit(1'b0, 1'b0);
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t6.rst_out",
              {dado_paralelo, dado_valido, erro_paridade, sobrescrita, recebendo}, 8'h00);
        check("t6.rst_parada", {7'h0, erro_parada}, 8'h00);
        serial_in = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expQ.delete();
        curExp = '0;
        modelValido = 1'b0;
        modelSobre = 1'b0;
        @(negedge clk);
        checkOutput("t6.pos_rst");
        applyStimulus(4'hA, 1'b0, 1'b0);
        checkOutput("t6");
        consume("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
